// File: rtl/char_rom_arbiter.sv
// Round-robin arbiter sharing one registered char-code ROM among N_REQ text drawers.
// One lookup is granted per clock, and each result is returned one cycle later to the requester that issued it.
module char_rom_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_xy,
  output logic [N_REQ-1:0]   gnt,
  output logic [7:0]         rom_xy,
  input  logic [6:0]         rom_code,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [6:0]         rsp_code
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_pend_tag;
  logic             r_pend_v;

  logic [N_REQ-1:0] w_gnt;
  logic [IDX_W-1:0] w_gidx;
  logic             w_any;

  // Scan starts at r_ptr and wraps around; the first active requester wins.
  always_comb begin
    int idx;
    idx    = 0;
    w_gnt  = '0;
    w_gidx = '0;
    w_any  = 1'b0;
    if (!rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!w_any && req[idx]) begin
          w_any      = 1'b1;
          w_gidx     = IDX_W'(idx);
          w_gnt[idx] = 1'b1;
        end
      end
    end
  end

  assign gnt    = w_gnt;
  assign rom_xy = w_any ? req_xy[8*int'(w_gidx) +: 8] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_pend_v   <= 1'b0;
      r_pend_tag <= '0;
    end else begin
      r_pend_v   <= w_any;
      r_pend_tag <= w_gidx;
      if (w_any)
        r_ptr <= (w_gidx == IDX_W'(N_REQ-1)) ? '0 : w_gidx + IDX_W'(1);
    end
  end

  // The ROM output register lines up with r_pend_*, so the response needs no extra staging.
  for (genvar i = 0; i < N_REQ; i++) begin : g_rsp
    assign rsp_valid[i] = r_pend_v && (r_pend_tag == IDX_W'(i));
  end

  assign rsp_code = r_pend_v ? rom_code : 7'h00;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Bench for char_rom_arbiter: a 2-requester and a 3-requester instance are each fed by a
// behavioural char ROM and checked every cycle against a round-robin reference model.
module tb_char_rom_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  rq [2];
  logic [31:0] xy [2];
  logic [3:0]  gn [2];
  logic [7:0]  rx [2];
  logic [3:0]  rv [2];
  logic [6:0]  rc [2];
  logic [6:0]  rom_q [2];

  logic [1:0] gnt2, rsv2;
  logic [2:0] gnt3, rsv3;

  char_rom_arbiter #(.N_REQ(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(rq[0][1:0]), .req_xy(xy[0][15:0]),
    .gnt(gnt2), .rom_xy(rx[0]), .rom_code(rom_q[0]),
    .rsp_valid(rsv2), .rsp_code(rc[0])
  );

  char_rom_arbiter #(.N_REQ(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(rq[1][2:0]), .req_xy(xy[1][23:0]),
    .gnt(gnt3), .rom_xy(rx[1]), .rom_code(rom_q[1]),
    .rsp_valid(rsv3), .rsp_code(rc[1])
  );

  assign gn[0] = {2'b00, gnt2};
  assign gn[1] = {1'b0, gnt3};
  assign rv[0] = {2'b00, rsv2};
  assign rv[1] = {1'b0, rsv3};

  // Behavioural char ROM: a few known glyphs; 8'h00 is unmapped and reads as zero.
  function automatic logic [6:0] rom_f(input logic [7:0] a);
    case (a)
      8'h00:   return 7'h00;
      8'h10:   return 7'h41;
      8'h21:   return 7'h4F;
      8'h16:   return 7'h42;
      8'h38:   return 7'h52;
      default: return a[6:0] ^ 7'h2A;
    endcase
  endfunction

  always @(posedge clk) begin
    rom_q[0] <= rom_f(rx[0]);
    rom_q[1] <= rom_f(rx[1]);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: remembers who was granted last and what each grant will return.
  int         nn    [2] = '{2, 3};
  int         last  [2] = '{1, 2};
  bit         pv    [2] = '{0, 0};
  int         ptag  [2] = '{0, 0};
  logic [6:0] pcode [2] = '{7'h00, 7'h00};

  // Entered just after a rising edge; inputs are already driven for this cycle.
  task automatic step();
    int eg;
    logic [31:0] egnt;
    logic [7:0]  exy;
    #4;
    for (int d = 0; d < 2; d++) begin
      eg = -1;
      if (!rst)
        for (int k = 1; k <= nn[d]; k++) begin
          int i;
          i = (last[d] + k) % nn[d];
          if (eg < 0 && rq[d][i]) eg = i;
        end
      egnt = (eg < 0) ? 32'd0 : (32'd1 << eg);
      exy  = (eg < 0) ? 8'h00 : xy[d][8*eg +: 8];
      chk($sformatf("n%0d_gnt", nn[d]), 32'(gn[d]), egnt);
      chk($sformatf("n%0d_rom_xy", nn[d]), 32'(rx[d]), 32'(exy));
      chk($sformatf("n%0d_rsp_valid", nn[d]), 32'(rv[d]), pv[d] ? (32'd1 << ptag[d]) : 32'd0);
      chk($sformatf("n%0d_rsp_code", nn[d]), 32'(rc[d]), pv[d] ? 32'(pcode[d]) : 32'd0);
      if (rst) begin
        last[d] = nn[d] - 1;
        pv[d]   = 1'b0;
      end else begin
        pv[d] = (eg >= 0);
        if (eg >= 0) begin
          ptag[d]  = eg;
          pcode[d] = rom_f(exy);
          last[d]  = eg;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rq[0] = '0; rq[1] = '0; xy[0] = '0; xy[1] = '0;
    @(posedge clk); #1;
    rq[0] = 4'b0011; rq[1] = 4'b0111;
    step(); step();
    chk("reset_rsp_valid", 32'(rv[0]), 32'd0);
    chk("reset_rsp_code", 32'(rc[0]), 32'd0);
    rst = 1'b0;
    rq[0] = 4'b0001; xy[0] = 32'h0000_0010; rq[1] = '0;
    step();
    chk("A_valid", 32'(rv[0]), 32'd1);
    chk("A_code", 32'(rc[0]), 32'h41);

    rst = 1'b1; rq[0] = '0; step(); rst = 1'b0;
    rq[0] = 4'b0011; xy[0] = 32'h0000_1621;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("alt_valid", 32'(rv[0]), (k % 2) ? 32'd2 : 32'd1);
      chk("alt_code", 32'(rc[0]), (k % 2) ? 32'h42 : 32'h4F);
    end

    rq[0] = 4'b0010; xy[0] = 32'h0000_3800;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("solo1_valid", 32'(rv[0]), 32'd2);
      chk("solo1_code", 32'(rc[0]), 32'h52);
    end

    rq[0] = 4'b0001; xy[0] = 32'h0;
    step();
    chk("unmapped_valid", 32'(rv[0]), 32'd1);
    chk("unmapped_code", 32'(rc[0]), 32'h00);
    rq[0] = '0; step(); step();
    chk("idle_valid", 32'(rv[0]), 32'd0);

    rq[0] = 4'b0001; rst = 1'b1;
    step();
    chk("rst_mid_valid", 32'(rv[0]), 32'd0);
    rst = 1'b0; rq[0] = 4'b0011; xy[0] = 32'h0000_1621;
    step();
    chk("post_rst_first", 32'(rv[0]), 32'd1);
    rq[0] = '0;

    rst = 1'b1; step(); rst = 1'b0;
    rq[1] = 4'b0111; xy[1] = 32'h0038_1621;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("n3_order", 32'(rv[1]), 32'd1 << (k % 3));
    end
    rq[1] = 4'b0101;
    for (int k = 0; k < 4; k++) step();

    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 24) == 0);
      rq[0] = 4'($urandom_range(0, 3));
      rq[1] = 4'($urandom_range(0, 7));
      xy[0] = {16'h0, 16'($urandom)};
      xy[1] = {8'h0, 24'($urandom)};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
